// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads to a synchronous
// instruction memory and buffers responses in a 2-entry FIFO ahead of decode.
module if_fetch_stage #(
    parameter int unsigned       DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] pc
);

    logic [DATA_W-1:0]         fpc;
    logic                      inflight;
    logic [DATA_W-1:0]         inflight_pc;
    logic [1:0][DATA_W-1:0]    buf_pc;
    logic [1:0][DATA_W-1:0]    buf_inst;
    logic                      rd_ptr;
    logic                      wr_ptr;
    logic [1:0]                count;
    logic                      pop;
    logic                      push;
    logic                      credit_ok;
    logic [2:0]                occupancy;

    assign pop       = inst_valid & inst_ready;
    assign push      = inflight & ~redirect_valid;
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    // Credit test "count + inflight - pop < 2", rearranged to avoid unsigned underflow.
    assign credit_ok = occupancy < (3'd2 + {2'b00, pop});

    assign imem_req   = rst & ~redirect_valid & credit_ok;
    assign inst_valid = (count != 2'd0) & ~redirect_valid;
    assign inst       = buf_inst[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];
    assign imem_addr  = fpc;
    assign pc         = fpc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            buf_pc      <= '0;
            buf_inst    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else if (redirect_valid) begin
            // Flush: drop buffered entries and the outstanding response.
            fpc      <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fpc;
                fpc         <= fpc + DATA_W'(1);
            end
            if (push) begin
                buf_pc[wr_ptr]   <= inflight_pc;
                buf_inst[wr_ptr] <= imem_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: scoreboard of expected {pc, inst} stream plus
// per-cycle handshake checks, directed scenarios and a randomized phase.
module tb_if_fetch_stage;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] inst;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [W-1:0] redirect_pc = '0;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_rdata = '0;
    logic         inst_valid;
    logic [W-1:0] inst;
    logic [W-1:0] inst_pc;
    logic         inst_ready = 1'b1;
    logic [W-1:0] pc;

    logic         imem_req2;
    logic [W-1:0] imem_addr2;
    logic [W-1:0] imem_rdata2 = '0;
    logic         inst_valid2;
    logic [W-1:0] inst2;
    logic [W-1:0] inst_pc2;
    logic [W-1:0] pc2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    exp_t sb[$];

    int           occ = 0;
    logic         req_d = 1'b0;
    logic         pop_c, push_c, exp_req;
    logic [W-1:0] exp2 = 16'hFFFE;
    int           n2 = 0;
    logic [W-1:0] first2 [4];
    logic [W-1:0] held_pc, held_inst;

    if_fetch_stage #(.DATA_W(W), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc(pc)
    );

    if_fetch_stage #(.DATA_W(W), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
        .inst_ready(1'b1), .pc(pc2)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memories: mem[a] = a ^ 16'hA500.
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= imem_addr ^ 16'hA500;
        if (imem_req2) imem_rdata2 <= imem_addr2 ^ 16'hA500;
    end

    task automatic chk16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Delivered stream after any restart is the contiguous word sequence from start.
    task automatic restart_stream(input logic [W-1:0] start);
        sb.delete();
        for (int i = 0; i < 512; i++) begin
            exp_t e;
            e.pc   = start + 16'(i);
            e.inst = e.pc ^ 16'hA500;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk1 ("rst_imem_req",   imem_req,   1'b0);
        chk1 ("rst_inst_valid", inst_valid, 1'b0);
        chk16("rst_inst",       inst,       16'h0000);
        chk16("rst_inst_pc",    inst_pc,    16'h0000);
        chk16("rst_imem_addr",  imem_addr,  16'h0000);
        chk16("rst_pc",         pc,         16'h0000);
        chk16("rst_pc_dut2",    pc2,        16'hFFFE);
        chk1 ("rst_valid_dut2", inst_valid2, 1'b0);
    endtask

    task automatic release_and_check_first();
        restart_stream(16'h0000);
        rst = 1'b1;
        @(negedge clk);
        chk1 ("c1_imem_req",   imem_req,   1'b1);
        chk16("c1_imem_addr",  imem_addr,  16'h0000);
        chk1 ("c1_inst_valid", inst_valid, 1'b0);
        @(negedge clk);
        chk1 ("c2_inst_valid", inst_valid, 1'b0);
        @(negedge clk);
        chk1 ("c3_inst_valid", inst_valid, 1'b1);
        chk16("c3_inst_pc",    inst_pc,    16'h0000);
        chk16("c3_inst",       inst,       16'hA500);
    endtask

    // Per-cycle monitor: handshake rules, credit rule, overflow assertion, scoreboard.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            occ   = 0;
            req_d = 1'b0;
        end else begin
            pop_c   = inst_valid & inst_ready;
            push_c  = req_d & ~redirect_valid;
            exp_req = ~redirect_valid && ((occ + int'(req_d) - int'(pop_c)) < 2);
            chk16("addr_eq_pc",  imem_addr,  pc);
            chk1 ("inst_valid",  inst_valid, (occ != 0) && !redirect_valid);
            chk1 ("imem_req",    imem_req,   exp_req);
            n_checks++;
            assert (!(push_c && occ == 2 && !pop_c)) else begin
                n_fail++;
                $display("FAIL fifo_overflow: push into full buffer at %0t", $time);
            end
            if (pop_c) begin
                chk1("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk16("inst_pc", inst_pc, e.pc);
                    chk16("inst",    inst,    e.inst);
                end
                n_pops++;
            end
            occ   = redirect_valid ? 0 : occ + int'(push_c) - int'(pop_c);
            req_d = exp_req;
        end
    end

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            exp2 = 16'hFFFE;
            n2   = 0;
        end else if (inst_valid2) begin
            chk16("dut2_inst_pc", inst_pc2, exp2);
            chk16("dut2_inst",    inst2,    exp2 ^ 16'hA500);
            if (n2 < 4) first2[n2] = inst_pc2;
            exp2 = exp2 + 16'h1;
            n2++;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        release_and_check_first();
        repeat (10) step();

        chk16("wrap_pc0", first2[0], 16'hFFFE);
        chk16("wrap_pc1", first2[1], 16'hFFFF);
        chk16("wrap_pc2", first2[2], 16'h0000);
        chk16("wrap_pc3", first2[3], 16'h0001);

        // Six-cycle stall, head must hold and requests must stop.
        step();
        inst_ready = 1'b0;
        @(negedge clk);
        held_pc   = inst_pc;
        held_inst = inst;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk16("stall_head_pc",   inst_pc, held_pc);
            chk16("stall_head_inst", inst,    held_inst);
        end
        chk1("stall_req_off", imem_req,   1'b0);
        chk1("stall_valid",   inst_valid, 1'b1);
        step();
        inst_ready = 1'b1;
        @(negedge clk);
        chk1("resume_req", imem_req, 1'b1);
        repeat (8) step();

        // Fill again, then redirect while full.
        inst_ready = 1'b0;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        inst_ready     = 1'b1;
        restart_stream(16'h0040);
        @(negedge clk);
        chk1("redir_valid_off", inst_valid, 1'b0);
        chk1("redir_req_off",   imem_req,   1'b0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk1 ("redir_n1_req",   imem_req,   1'b1);
        chk16("redir_n1_addr",  imem_addr,  16'h0040);
        chk1 ("redir_n1_valid", inst_valid, 1'b0);
        step();
        @(negedge clk);
        chk1("redir_n2_valid", inst_valid, 1'b0);
        step();
        @(negedge clk);
        chk1 ("redir_n3_valid", inst_valid, 1'b1);
        chk16("redir_n3_pc",    inst_pc,    16'h0040);
        chk16("redir_n3_inst",  inst,       16'hA540);
        repeat (5) step();

        // Back-to-back redirects: last one wins.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        restart_stream(16'h0010);
        step();
        redirect_pc = 16'h0020;
        restart_stream(16'h0020);
        step();
        redirect_valid = 1'b0;
        repeat (20) step();

        // Randomized ready and occasional redirects.
        for (int i = 0; i < 400; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 16'($urandom);
                restart_stream(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (5) step();

        // Short asynchronous reset pulse between clock edges.
        #1 rst = 1'b0;
        #1 check_reset_outputs();
        release_and_check_first();
        repeat (30) step();

        chk1("enough_deliveries", n_pops > 150, 1'b1);
        chk1("dut2_deliveries",   n2 > 20,      1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
